// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the ALU opcode constants and the state type of the multiply
// sequencer. Both the shared ALU and alu_mul_seq import this package.
package alu_pkg;

   localparam logic [2:0] ALU_PASS_B   = 3'b000;
   localparam logic [2:0] ALU_ADD      = 3'b010;
   localparam logic [2:0] ALU_SUBTRACT = 3'b011;
   localparam logic [2:0] ALU_AND      = 3'b100;
   localparam logic [2:0] ALU_OR       = 3'b101;
   localparam logic [2:0] ALU_XOR      = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU used by the EX stage and the multiply sequencer.
// Ports:
//   a, b       operands
//   cntrl      opcode (alu_pkg constants)
//   result     operation result
//   carry_out  carry of ADD, not-borrow of SUBTRACT, 0 otherwise
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       cntrl,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] diff_s;

   // Wide add/subtract so the carry is the top bit.
   always_comb begin
      sum_s  = {1'b0, a} + {1'b0, b};
      diff_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   end

   // Opcode decode.
   always_comb begin
      result    = {WIDTH{1'b0}};
      carry_out = 1'b0;
      case (cntrl)
         ALU_PASS_B:   result = b;
         ALU_ADD: begin
            result    = sum_s[WIDTH-1:0];
            carry_out = sum_s[WIDTH];
         end
         ALU_SUBTRACT: begin
            result    = diff_s[WIDTH-1:0];
            carry_out = diff_s[WIDTH];
         end
         ALU_AND:      result = a & b;
         ALU_OR:       result = a | b;
         ALU_XOR:      result = a ^ b;
         default: begin
            result    = {WIDTH{1'b0}};
            carry_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiplier that borrows the shared ALU.
// Each granted RUN cycle adds (Q[0] ? M : 0) to the partial product P via
// the ALU, then shifts M left and Q right. The low WIDTH bits of the
// product are returned (same for signed and unsigned operands).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, op_a, op_b    request and operands (sampled when accepted)
//   busy, done           RUN indicator, one-cycle completion pulse
//   product, product_zero  registered result and zero flag
//   alu_req/alu_gnt      ALU arbitration (grant is same-cycle)
//   alu_a/alu_b/alu_cntrl  ALU operand/opcode drive
//   alu_result/alu_carry_out  ALU response
// Optional build macro: MUL_EARLY_TERM_EN -- finish as soon as the
// remaining multiplier bits are all zero.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             product_zero,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cntrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry_out
);

   mul_state_t       state_r;
   mul_state_t       state_next_s;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] q_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] carry_cnt_r;
   logic [WIDTH-1:0] product_r;
   logic             product_zero_r;
   logic             step_s;
   logic             last_step_s;
   logic             accept_s;
   logic [WIDTH-1:0] q_shift_s;

   // Step qualification, accept decode and final-step detection.
   always_comb begin
      step_s    = (state_r == RUN) && alu_gnt;
      accept_s  = ((state_r == IDLE) || (state_r == DONE)) && start;
      q_shift_s = q_r >> 1;
`ifdef MUL_EARLY_TERM_EN
      // Once the unshifted multiplier bits are exhausted, further steps add 0.
      last_step_s = step_s && ((count_r == CNT_W'(WIDTH - 1)) ||
                               (q_shift_s == {WIDTH{1'b0}}));
`else
      last_step_s = step_s && (count_r == CNT_W'(WIDTH - 1));
`endif
   end

   // Next-state and output decode.
   always_comb begin
      state_next_s = state_r;
      busy         = 1'b0;
      done         = 1'b0;
      alu_req      = 1'b0;
      alu_a        = {WIDTH{1'b0}};
      alu_b        = {WIDTH{1'b0}};
      alu_cntrl    = ALU_PASS_B;
      case (state_r)
         IDLE: begin
            if (start) state_next_s = RUN;
            else       state_next_s = IDLE;
         end
         RUN: begin
            busy      = 1'b1;
            alu_req   = 1'b1;
            alu_cntrl = ALU_ADD;
            alu_a     = p_r;
            if (q_r[0]) alu_b = m_r;
            else        alu_b = {WIDTH{1'b0}};
            if (last_step_s) state_next_s = DONE;
            else             state_next_s = RUN;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_next_s = RUN;
            else       state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_next_s;
   end

   // Datapath registers: operand load on accept, shift-and-add on granted steps.
   always_ff @(posedge clk) begin
      if (reset) begin
         p_r         <= {WIDTH{1'b0}};
         m_r         <= {WIDTH{1'b0}};
         q_r         <= {WIDTH{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         carry_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         p_r         <= {WIDTH{1'b0}};
         m_r         <= op_a;
         q_r         <= op_b;
         count_r     <= {CNT_W{1'b0}};
         carry_cnt_r <= {CNT_W{1'b0}};
      end else if (step_s) begin
         p_r     <= alu_result;
         m_r     <= m_r << 1;
         q_r     <= q_shift_s;
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         // Debug only: number of steps whose add carried out of WIDTH bits.
         if (alu_carry_out) carry_cnt_r <= carry_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         else               carry_cnt_r <= carry_cnt_r;
      end else begin
         p_r         <= p_r;
         m_r         <= m_r;
         q_r         <= q_r;
         count_r     <= count_r;
         carry_cnt_r <= carry_cnt_r;
      end
   end

   // Result register: captured on the final step, held otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         product_r      <= {WIDTH{1'b0}};
         product_zero_r <= 1'b1;
      end else if (last_step_s) begin
         product_r      <= alu_result;
         product_zero_r <= (alu_result == {WIDTH{1'b0}});
      end else begin
         product_r      <= product_r;
         product_zero_r <= product_zero_r;
      end
   end

   assign product      = product_r;
   assign product_zero = product_zero_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq driving the shared alu.
module tb_alu_mul_seq;
   import alu_pkg::*;

   localparam int WIDTH = 64;
   localparam int CNT_W = 7;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] op_a = '0;
   logic [WIDTH-1:0] op_b = '0;
   logic             busy, done, product_zero, alu_req;
   logic [WIDTH-1:0] product, alu_a, alu_b, alu_result;
   logic             alu_gnt = 1'b1;
   logic [2:0]       alu_cntrl;
   logic             alu_carry_out;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [WIDTH-1:0] prod;
      int               steps;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .product(product), .product_zero(product_zero),
      .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
      .alu_cntrl(alu_cntrl), .alu_result(alu_result), .alu_carry_out(alu_carry_out)
   );

   alu #(.WIDTH(WIDTH)) u_alu (
      .a(alu_a), .b(alu_b), .cntrl(alu_cntrl),
      .result(alu_result), .carry_out(alu_carry_out)
   );

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
      total++;
      if (obs !== expv) $display("FAIL %s: got %h expected %h", tag, obs, expv);
      else passed++;
   endtask

   function automatic int exp_steps(input logic [WIDTH-1:0] b);
      int hi;
`ifdef MUL_EARLY_TERM_EN
      hi = 0;
      for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i;
      return hi + 1;
`else
      return WIDTH;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one multiply and follow it to done. rnd: random grant;
   // inject_cyc > 0: pulse start with other operands at that cycle.
   // Returns in the done cycle so a follow-on start lands in DONE.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit rnd, input int inject_cyc);
      exp_t e;
      logic [WIDTH-1:0] mp, mm, mq, mb;
      int cyc, stalls, mism, got_done;
      e.prod  = a * b;
      e.steps = exp_steps(b);
      exp_q.push_back(e);
      op_a = a; op_b = b; start = 1'b1;
      mp = '0; mm = a; mq = b;
      tick();
      start = 1'b0;
      op_a = '0; op_b = '0;
      cyc = 1; stalls = 0; mism = 0; got_done = 0;
      while (cyc < 400) begin
         if (done) begin
            got_done = 1;
            break;
         end
         if (cyc == inject_cyc) begin
            start = 1'b1; op_a = 64'd5; op_b = 64'd5;
         end else begin
            start = 1'b0;
         end
         alu_gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (busy) begin
            mb = mq[0] ? mm : '0;
            if (alu_a !== mp || alu_b !== mb || alu_req !== 1'b1 || alu_cntrl !== ALU_ADD) mism++;
            if (alu_gnt) begin
               mp = mp + mb; mm = mm << 1; mq = mq >> 1;
            end else begin
               stalls++;
            end
         end else begin
            mism++;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      alu_gnt = 1'b1;
      chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
      e = exp_q.pop_front();
      chk({tag, "_product"}, product, e.prod);
      chk({tag, "_zero"}, 64'(product_zero), 64'(e.prod == '0));
      chk({tag, "_latency"}, 64'(cyc), 64'(1 + e.steps + stalls));
      chk({tag, "_datapath_mism"}, 64'(mism), 64'd0);
   endtask

   initial begin
      int pulses;
      logic [WIDTH-1:0] prev;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_req", 64'(alu_req), 64'd0);
      chk("rst_product", product, 64'd0);
      chk("rst_zero", 64'(product_zero), 64'd1);
      chk("rst_cntrl", 64'(alu_cntrl), 64'd0);
      tick();

      run_op("basic", 64'd3, 64'd5, 1'b0, 0);
      tick();
      // Outside RUN the ALU drive is idle and the product is held.
      chk("idle_alu_a", alu_a, 64'd0);
      chk("idle_alu_b", alu_b, 64'd0);
      chk("idle_hold", product, 64'd15);
      chk("done_pulse", 64'(done), 64'd0);
      run_op("neg1x7", 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1'b0, 0);
      tick();
      run_op("wrap0", 64'h8000_0000_0000_0000, 64'd2, 1'b0, 0);
      tick();
      run_op("stall", 64'd123456789, 64'd987654321, 1'b1, 0);
      // Back-to-back: next start issued while in DONE.
      run_op("b2b", 64'd2, 64'd9, 1'b0, 0);
      tick();
      run_op("midstart", 64'h0000_0000_DEAD_BEEF, 64'h0123_4567_89AB_CDEF, 1'b1, 10);
      tick();
      run_op("esc_b1", 64'd77, 64'd1, 1'b0, 0);
      tick();
      run_op("esc_b0", 64'd77, 64'd0, 1'b0, 0);
      tick();
      run_op("esc_bmsb", 64'd3, 64'h8000_0000_0000_0000, 1'b0, 0);
      tick();
      run_op("pre_abort", 64'd11, 64'd13, 1'b0, 0);
      tick();

      // Abort: reset after 30 steps of a full-length multiply.
      op_a = 64'd1000; op_b = 64'hFFFF_FFFF_FFFF_FFFF; start = 1'b1;
      tick();
      start = 1'b0;
      alu_gnt = 1'b1;
      repeat (30) tick();
      prev = {63'd0, busy};
      chk("abort_busy_before", prev, 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_product", product, 64'd0);
      chk("abort_zero", 64'(product_zero), 64'd1);
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         if (done) pulses++;
         tick();
      end
      chk("abort_no_done", 64'(pulses), 64'd0);
      run_op("after_abort", 64'd6, 64'd7, 1'b0, 0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
